// File: rtl/nmcu_pkg.sv
// Shared NMCU datapath widths for the operand and partial-sum paths.
package nmcu_pkg;
  parameter int DATA_WIDTH = 8;
  parameter int PSUM_WIDTH = 32;
endpackage

// File: rtl/pe_tile_scheduler.sv
// Walks a job's K tiles: operand fetch, PE command, result return; 4 cycles + PE latency per tile.
// Stalls on op_rd_valid_i, pe_cmd_ready_i, pe_done_i and res_ready_i; accepts one job only when idle.
module pe_tile_scheduler #(
  parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
  parameter int PSUM_WIDTH = nmcu_pkg::PSUM_WIDTH,
  parameter int K_W        = 8,
  parameter int ADDR_W     = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               job_valid_i,
  output logic                               job_ready_o,
  input  logic [K_W-1:0]                     job_k_len_i,
  input  logic [ADDR_W-1:0]                  job_a_base_i,
  input  logic [ADDR_W-1:0]                  job_b_base_i,
  input  logic                               job_accum_i,
  output logic                               op_rd_req_o,
  output logic [ADDR_W-1:0]                  op_rd_addr_a_o,
  output logic [ADDR_W-1:0]                  op_rd_addr_b_o,
  input  logic                               op_rd_valid_i,
  input  logic [3:0][DATA_WIDTH-1:0]         op_a_data_i,
  input  logic [3:0][DATA_WIDTH-1:0]         op_b_data_i,
  output logic                               pe_cmd_valid_o,
  input  logic                               pe_cmd_ready_i,
  output logic                               pe_accum_en_o,
  output logic [3:0][DATA_WIDTH-1:0]         pe_operand_a_o,
  output logic [3:0][DATA_WIDTH-1:0]         pe_operand_b_o,
  input  logic                               pe_done_i,
  input  logic [3:0][3:0][PSUM_WIDTH-1:0]    pe_result_i,
  output logic                               res_valid_o,
  input  logic                               res_ready_i,
  output logic [3:0][3:0][PSUM_WIDTH-1:0]    res_data_o,
  output logic                               busy_o,
  output logic                               err_o
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_OP, ISSUE, WAIT_PE, RESULT} state_t;

  state_t                     state_q, state_d;
  logic [K_W-1:0]             k_idx_q, k_len_q;
  logic [ADDR_W-1:0]          a_base_q, b_base_q;
  logic                       accum_q, err_q;
  logic [3:0][DATA_WIDTH-1:0] op_a_q, op_b_q;
  logic                       last_tile;

  assign last_tile      = (k_idx_q == k_len_q - 1'b1);
  assign op_rd_addr_a_o = a_base_q + ADDR_W'(k_idx_q);
  assign op_rd_addr_b_o = b_base_q + ADDR_W'(k_idx_q);
  assign pe_operand_a_o = op_a_q;
  assign pe_operand_b_o = op_b_q;
  assign err_o          = err_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Handshake outputs are forced low combinationally for the whole reset window.
  always_comb begin
    state_d        = state_q;
    job_ready_o    = 1'b0;
    op_rd_req_o    = 1'b0;
    pe_cmd_valid_o = 1'b0;
    pe_accum_en_o  = 1'b0;
    res_valid_o    = 1'b0;
    busy_o         = 1'b0;
    if (!rst) begin
      busy_o = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          job_ready_o = 1'b1;
          if (job_valid_i && job_k_len_i != '0) state_d = FETCH;
        end
        FETCH: begin
          op_rd_req_o = 1'b1;
          state_d     = WAIT_OP;
        end
        WAIT_OP: if (op_rd_valid_i) state_d = ISSUE;
        ISSUE: begin
          pe_cmd_valid_o = 1'b1;
          pe_accum_en_o  = (k_idx_q == '0) ? accum_q : 1'b1;
          if (pe_cmd_ready_i) state_d = WAIT_PE;
        end
        WAIT_PE: if (pe_done_i) state_d = last_tile ? RESULT : FETCH;
        RESULT: begin
          res_valid_o = 1'b1;
          if (res_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_idx_q    <= '0;
      k_len_q    <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      accum_q    <= 1'b0;
      err_q      <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_data_o <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (job_valid_i) begin
          k_len_q  <= job_k_len_i;
          a_base_q <= job_a_base_i;
          b_base_q <= job_b_base_i;
          accum_q  <= job_accum_i;
          k_idx_q  <= '0;
          err_q    <= (job_k_len_i == '0);
        end
        WAIT_OP: if (op_rd_valid_i) begin
          op_a_q <= op_a_data_i;
          op_b_q <= op_b_data_i;
        end
        WAIT_PE: if (pe_done_i) begin
          if (last_tile) res_data_o <= pe_result_i;
          else           k_idx_q    <= k_idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Scoreboard bench for pe_tile_scheduler: operand-buffer and PE responders with expected queues.
module tb_pe_tile_scheduler;
  localparam int DW     = nmcu_pkg::DATA_WIDTH;
  localparam int PW     = nmcu_pkg::PSUM_WIDTH;
  localparam int KW     = 8;
  localparam int AW     = 10;
  localparam int PE_LAT = 2;

  typedef logic [3:0][DW-1:0]       row_t;
  typedef logic [3:0][3:0][PW-1:0]  mat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid = 1'b0, job_ready_o;
  logic [KW-1:0] job_k_len = '0;
  logic [AW-1:0] job_a_base = '0, job_b_base = '0;
  logic          job_accum = 1'b0;
  logic          op_rd_req_o;
  logic [AW-1:0] op_rd_addr_a_o, op_rd_addr_b_o;
  logic          op_rd_valid = 1'b0;
  row_t          op_a_data = '0, op_b_data = '0;
  logic          pe_cmd_valid_o, pe_cmd_ready = 1'b0, pe_accum_en_o;
  row_t          pe_operand_a_o, pe_operand_b_o;
  logic          pe_done = 1'b0;
  mat_t          pe_result = '0;
  logic          res_valid_o, res_ready = 1'b0;
  mat_t          res_data_o;
  logic          busy_o, err_o;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] exp_addr_a_q[$], exp_addr_b_q[$];
  logic          exp_acc_q[$];
  row_t          exp_opa_q[$], exp_opb_q[$];
  mat_t          exp_res_q[$];

  pe_tile_scheduler #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .K_W(KW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .job_valid_i(job_valid), .job_ready_o(job_ready_o), .job_k_len_i(job_k_len),
    .job_a_base_i(job_a_base), .job_b_base_i(job_b_base), .job_accum_i(job_accum),
    .op_rd_req_o(op_rd_req_o), .op_rd_addr_a_o(op_rd_addr_a_o), .op_rd_addr_b_o(op_rd_addr_b_o),
    .op_rd_valid_i(op_rd_valid), .op_a_data_i(op_a_data), .op_b_data_i(op_b_data),
    .pe_cmd_valid_o(pe_cmd_valid_o), .pe_cmd_ready_i(pe_cmd_ready), .pe_accum_en_o(pe_accum_en_o),
    .pe_operand_a_o(pe_operand_a_o), .pe_operand_b_o(pe_operand_b_o),
    .pe_done_i(pe_done), .pe_result_i(pe_result),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready), .res_data_o(res_data_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic row_t op_row(input logic [AW-1:0] addr, input logic [7:0] salt);
    row_t r;
    for (int i = 0; i < 4; i++) r[i] = (DW'(addr) ^ DW'(salt)) + DW'(i);
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) m[i][j] = PW'($urandom);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    exp_addr_a_q.delete(); exp_addr_b_q.delete(); exp_acc_q.delete();
    exp_opa_q.delete(); exp_opb_q.delete(); exp_res_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({job_ready_o, op_rd_req_o, pe_cmd_valid_o, pe_accum_en_o, res_valid_o, err_o, busy_o} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0000000", {job_ready_o, op_rd_req_o, pe_cmd_valid_o,
               pe_accum_en_o, res_valid_o, err_o, busy_o});
    end
    checks++;
    if (res_data_o !== '0 || pe_operand_a_o !== '0 || pe_operand_b_o !== '0) begin
      failures++;
      $display("FAIL reset_data got res=%h opa=%h opb=%h want=0", res_data_o, pe_operand_a_o, pe_operand_b_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (job_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b busy=%b want ready=1 busy=0", job_ready_o, busy_o);
    end
  endtask

  // Runs one job with both responders; abort_tile >= 0 resets while that tile's PE op is in flight.
  task automatic run_job(input int k_len, input logic [AW-1:0] a_base, input logic [AW-1:0] b_base,
                         input logic accum, input int cmd_stall, input int res_stall,
                         input int abort_tile, input bit hold_valid);
    int tile = 0, pe_cnt = 0, stall_left = cmd_stall, res_left = res_stall;
    bit rd_pend = 0, hs_pend = 0, done = 0;
    logic [AW-1:0] pa = '0, pb = '0;
    mat_t r, last_res = '0;
    checks++;
    if (job_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL job_ready_idle got=%b want=1", job_ready_o);
    end
    for (int k = 0; k < k_len; k++) begin
      exp_addr_a_q.push_back(a_base + AW'(k));
      exp_addr_b_q.push_back(b_base + AW'(k));
      exp_acc_q.push_back((k == 0) ? accum : 1'b1);
    end
    job_valid = 1'b1; job_k_len = KW'(k_len); job_a_base = a_base; job_b_base = b_base; job_accum = accum;
    tick();
    if (hold_valid) begin
      job_a_base = a_base ^ 10'h155; job_b_base = b_base ^ 10'h0AA; job_k_len = 8'd1; job_accum = ~accum;
    end else begin
      job_valid = 1'b0;
    end
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      op_rd_valid = 1'b0; pe_done = 1'b0; pe_cmd_ready = 1'b0; res_ready = 1'b0;
      if (hs_pend) begin
        job_valid = 1'b0;
        checks++;
        if (res_valid_o !== 1'b0 || job_ready_o !== 1'b1 || busy_o !== 1'b0) begin
          failures++;
          $display("FAIL after_result got valid=%b ready=%b busy=%b want 0 1 0", res_valid_o, job_ready_o, busy_o);
        end
        checks++;
        if (res_data_o !== last_res) begin
          failures++;
          $display("FAIL res_hold got=%h want=%h", res_data_o, last_res);
        end
        done = 1;
      end else begin
        checks++;
        if (job_ready_o !== 1'b0 || busy_o !== 1'b1) begin
          failures++;
          $display("FAIL busy_hold got ready=%b busy=%b want ready=0 busy=1", job_ready_o, busy_o);
        end
        if (rd_pend) begin
          rd_pend = 0;
          op_rd_valid = 1'b1;
          op_a_data = op_row(pa, 8'h3C);
          op_b_data = op_row(pb, 8'hC3);
          exp_opa_q.push_back(op_a_data);
          exp_opb_q.push_back(op_b_data);
        end
        if (op_rd_req_o) begin
          checks++;
          if (exp_addr_a_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_read got addr_a=%h want no read", op_rd_addr_a_o);
          end else begin
            pa = exp_addr_a_q.pop_front();
            pb = exp_addr_b_q.pop_front();
            if ({op_rd_addr_a_o, op_rd_addr_b_o} !== {pa, pb}) begin
              failures++;
              $display("FAIL rd_addr got a=%h b=%h want a=%h b=%h", op_rd_addr_a_o, op_rd_addr_b_o, pa, pb);
            end
            rd_pend = 1;
          end
        end
        if (pe_cmd_valid_o) begin
          checks++;
          if (exp_acc_q.size() == 0 || exp_opa_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_cmd got accum_en=%b want no command", pe_accum_en_o);
          end else if (pe_accum_en_o !== exp_acc_q[0] ||
                       {pe_operand_a_o, pe_operand_b_o} !== {exp_opa_q[0], exp_opb_q[0]}) begin
            failures++;
            $display("FAIL pe_cmd got acc=%b a=%h b=%h want acc=%b a=%h b=%h", pe_accum_en_o,
                     pe_operand_a_o, pe_operand_b_o, exp_acc_q[0], exp_opa_q[0], exp_opb_q[0]);
          end
          if (stall_left > 0) stall_left--;
          else begin
            pe_cmd_ready = 1'b1;
            if (exp_acc_q.size() > 0) void'(exp_acc_q.pop_front());
            if (exp_opa_q.size() > 0) void'(exp_opa_q.pop_front());
            if (exp_opb_q.size() > 0) void'(exp_opb_q.pop_front());
            pe_cnt = PE_LAT;
          end
        end else if (pe_cnt > 0) begin
          pe_cnt--;
          if (pe_cnt == 0 && tile == abort_tile) begin
            rst = 1'b1;
            tick();
            checks++;
            if ({job_ready_o, op_rd_req_o, pe_cmd_valid_o, pe_accum_en_o, res_valid_o, err_o, busy_o} !== 7'b0 ||
                res_data_o !== '0 || pe_operand_a_o !== '0) begin
              failures++;
              $display("FAIL abort_outputs got ctrl=%b res=%h opa=%h want all 0", {job_ready_o, op_rd_req_o,
                       pe_cmd_valid_o, pe_accum_en_o, res_valid_o, err_o, busy_o}, res_data_o, pe_operand_a_o);
            end
            rst = 1'b0;
            #1;
            checks++;
            if (job_ready_o !== 1'b1 || busy_o !== 1'b0) begin
              failures++;
              $display("FAIL abort_release got ready=%b busy=%b want ready=1 busy=0", job_ready_o, busy_o);
            end
            clear_queues();
            done = 1;
          end else if (pe_cnt == 0) begin
            r = rand_mat();
            pe_done = 1'b1;
            pe_result = r;
            tile++;
            if (tile == k_len) exp_res_q.push_back(r);
          end
        end
        if (res_valid_o) begin
          checks++;
          if (exp_res_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result got=%h want no result", res_data_o);
          end else if (res_data_o !== exp_res_q[0]) begin
            failures++;
            $display("FAIL res_data got=%h want=%h", res_data_o, exp_res_q[0]);
          end
          if (res_left > 0) res_left--;
          else begin
            res_ready = 1'b1;
            if (exp_res_q.size() > 0) last_res = exp_res_q.pop_front();
            hs_pend = 1;
          end
        end
      end
      if (!done) tick();
    end
    job_valid = 1'b0; op_rd_valid = 1'b0; pe_done = 1'b0; pe_cmd_ready = 1'b0; res_ready = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL job_timeout got done=0 want done=1 (k_len=%0d)", k_len);
      clear_queues();
    end
    if (abort_tile < 0) begin
      checks++;
      if (exp_addr_a_q.size() != 0 || exp_acc_q.size() != 0 || exp_res_q.size() != 0) begin
        failures++;
        $display("FAIL leftover got reads=%0d cmds=%0d results=%0d want 0 0 0",
                 exp_addr_a_q.size(), exp_acc_q.size(), exp_res_q.size());
      end
      clear_queues();
    end
  endtask

  task automatic test_multi_tile();
    run_job(3, 10'h010, 10'h020, 1'b0, 0, 0, -1, 1'b0);
  endtask

  task automatic test_single_accum();
    run_job(1, 10'h055, 10'h066, 1'b1, 0, 0, -1, 1'b0);
  endtask

  task automatic test_zero_len();
    int err_cnt = 0;
    job_valid = 1'b1; job_k_len = '0; job_a_base = 10'h0AB; job_b_base = 10'h0CD; job_accum = 1'b1;
    tick();
    job_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (err_o === 1'b1) err_cnt++;
      checks++;
      if ({op_rd_req_o, pe_cmd_valid_o, res_valid_o, busy_o} !== 4'b0 || job_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL zero_len_quiet got req/cmd/res/busy=%b ready=%b want 0000 1",
                 {op_rd_req_o, pe_cmd_valid_o, res_valid_o, busy_o}, job_ready_o);
      end
      if (c == 0) begin
        checks++;
        if (err_o !== 1'b1) begin
          failures++;
          $display("FAIL zero_len_err got=%b want=1", err_o);
        end
      end
      tick();
    end
    checks++;
    if (err_cnt != 1) begin
      failures++;
      $display("FAIL zero_len_pulses got=%0d want=1", err_cnt);
    end
  endtask

  task automatic test_addr_wrap();
    run_job(2, 10'h3FF, 10'h3FE, 1'b0, 0, 0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_job(2, 10'h100, 10'h200, 1'b1, 5, 3, -1, 1'b0);
  endtask

  task automatic test_abort();
    run_job(4, 10'h040, 10'h080, 1'b1, 0, 0, 1, 1'b0);
    run_job(2, 10'h040, 10'h080, 1'b0, 0, 0, -1, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    pe_done = 1'b1; op_rd_valid = 1'b1; pe_result = rand_mat();
    tick();
    pe_done = 1'b0; op_rd_valid = 1'b0;
    checks++;
    if ({busy_o, pe_cmd_valid_o, res_valid_o, op_rd_req_o} !== 4'b0) begin
      failures++;
      $display("FAIL ignored_inputs got busy/cmd/res/req=%b want 0000",
               {busy_o, pe_cmd_valid_o, res_valid_o, op_rd_req_o});
    end
  endtask

  task automatic test_back_to_back();
    run_job(2, 10'h123, 10'h234, 1'b0, 1, 0, -1, 1'b1);
    run_job(3, 10'h1F0, 10'h0F0, 1'b1, 0, 1, -1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_multi_tile();
    test_single_accum();
    test_zero_len();
    test_addr_wrap();
    test_backpressure();
    test_abort();
    test_ignored_inputs();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
